// File: rtl/jpeg_stuff_pkg.sv
// Shared constants and FSM encoding for the JPEG 0xFF byte-stuffing packer.
package jpeg_stuff_pkg;

    localparam logic [7:0]  BYTE_FF    = 8'hFF;
    localparam logic [7:0]  STUFF_BYTE = 8'h00;
    localparam int unsigned BUF_BYTES  = 12;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FLUSH
    } state_e;

    function automatic logic is_ff(input logic [7:0] b);
        return b == BYTE_FF;
    endfunction

endpackage

// File: rtl/ff_stuff_packer_if.sv
// Upstream FIFO read port and packed-output bundle for ff_stuff_packer.
interface ff_stuff_packer_if;

    logic        fifo_empty;
    logic        fifo_read_req;
    logic [31:0] fifo_rdata;
    logic        fifo_rdata_valid;
    logic        eof_in;
    logic [31:0] jpeg_bitstream;
    logic        data_ready;
    logic        eof_data_partial_ready;
    logic [1:0]  eof_byte_count;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  fifo_rdata_valid,
        input  eof_in,
        output fifo_read_req,
        output jpeg_bitstream,
        output data_ready,
        output eof_data_partial_ready,
        output eof_byte_count
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output fifo_rdata_valid,
        output eof_in,
        input  fifo_read_req,
        input  jpeg_bitstream,
        input  data_ready,
        input  eof_data_partial_ready,
        input  eof_byte_count
    );

endinterface

// File: rtl/ff_byte_expand.sv
// Inserts 0x00 after every 0xFF byte of a 32-bit word; result is left-justified in 64 bits.
module ff_byte_expand
    import jpeg_stuff_pkg::*;
(
    input  logic [31:0] word,
    output logic [63:0] expanded,
    output logic [3:0]  byte_count
);

    logic [7:0] slot [8];
    logic [3:0] pos;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            slot[i] = STUFF_BYTE;
        end
        pos = '0;
        for (int b = 0; b < 4; b++) begin
            slot[pos[2:0]] = word[31 - 8*b -: 8];
            pos = pos + 4'd1;
            if (is_ff(word[31 - 8*b -: 8])) begin
                slot[pos[2:0]] = STUFF_BYTE;
                pos = pos + 4'd1;
            end
        end
        byte_count = pos;
        expanded = '0;
        for (int i = 0; i < 8; i++) begin
            expanded[63 - 8*i -: 8] = slot[i];
        end
    end

endmodule

// File: rtl/ff_stuff_packer.sv
// Byte-stuffs entropy-coded words into a 12-byte FIFO and emits 32-bit words, with a
// final partial word flushed after end-of-image.
module ff_stuff_packer #(
    parameter int unsigned BUF_BYTES = 12
) (
    input  logic              clk,
    input  logic              rst,
    ff_stuff_packer_if.master bus
);

    import jpeg_stuff_pkg::*;

    state_e      state_q, state_d;
    logic [7:0]  stash_q [BUF_BYTES];
    logic [7:0]  stash_d [BUF_BYTES];
    logic [3:0]  occ_q, occ_d;
    logic [31:0] word_q, word_d;
    logic        ready_q, ready_d;
    logic        eof_q, eof_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        inflight_q;
    logic        drop_q;

    logic [63:0] exp_word;
    logic [3:0]  exp_cnt;
    logic        in_en;
    logic        out_en;
    logic [3:0]  base;
    logic [4:0]  occ_sum;
    logic        read_req;
    logic [31:0] flush_word;

    ff_byte_expand u_expand (
        .word       (bus.fifo_rdata),
        .expanded   (exp_word),
        .byte_count (exp_cnt)
    );

    // drop_q swallows a stale valid in the first cycle after reset release.
    assign in_en   = bus.fifo_rdata_valid && !drop_q && (state_q != FLUSH);
    assign out_en  = (occ_q >= 4'd4) && (state_q != FLUSH);
    assign base    = out_en ? occ_q - 4'd4 : occ_q;
    assign occ_sum = {1'b0, base} + (in_en ? {1'b0, exp_cnt} : 5'd0);
    assign occ_d   = (state_q == FLUSH) ? 4'd0 : occ_sum[3:0];

    // Capping occ_next at 4 leaves room for a worst-case 8-byte word next cycle.
    assign read_req = rst && !bus.fifo_empty && (state_q == RUN || state_q == DRAIN)
                      && (occ_sum <= 5'd4);

    always_comb begin
        for (int i = 0; i < BUF_BYTES - 4; i++) begin
            stash_d[i] = out_en ? stash_q[i + 4] : stash_q[i];
        end
        for (int i = BUF_BYTES - 4; i < BUF_BYTES; i++) begin
            stash_d[i] = out_en ? STUFF_BYTE : stash_q[i];
        end
        if (in_en) begin
            for (int k = 0; k < 8; k++) begin
                if ((4'(k) < exp_cnt) && (({1'b0, base} + 5'(k)) < 5'(BUF_BYTES))) begin
                    stash_d[base + 4'(k)] = exp_word[63 - 8*k -: 8];
                end
            end
        end
    end

    always_comb begin
        flush_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (occ_q > 4'(i)) begin
                flush_word[31 - 8*i -: 8] = stash_q[i];
            end
        end
    end

    always_comb begin
        word_d  = word_q;
        ready_d = 1'b0;
        eof_d   = 1'b0;
        cnt_d   = '0;
        if (state_q == FLUSH) begin
            word_d = flush_word;
            eof_d  = 1'b1;
            cnt_d  = occ_q[1:0];
        end else if (out_en) begin
            word_d  = {stash_q[0], stash_q[1], stash_q[2], stash_q[3]};
            ready_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (bus.eof_in) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.fifo_empty && !inflight_q && !bus.fifo_rdata_valid && (occ_q < 4'd4)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            occ_q      <= '0;
            word_q     <= '0;
            ready_q    <= 1'b0;
            eof_q      <= 1'b0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b1;
            for (int i = 0; i < BUF_BYTES; i++) begin
                stash_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            word_q     <= word_d;
            ready_q    <= ready_d;
            eof_q      <= eof_d;
            cnt_q      <= cnt_d;
            inflight_q <= read_req;
            drop_q     <= 1'b0;
            stash_q    <= stash_d;
        end
    end

    assign bus.fifo_read_req          = read_req;
    assign bus.jpeg_bitstream         = word_q;
    assign bus.data_ready             = ready_q;
    assign bus.eof_data_partial_ready = eof_q;
    assign bus.eof_byte_count         = cnt_q;

endmodule

// File: tb/tb_ff_stuff_packer.sv
// Self-checking bench: directed vector table, reset corner case, random frames vs byte model.
module tb_ff_stuff_packer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ff_stuff_packer_if bus ();

    ff_stuff_packer #(.BUF_BYTES(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        int          n_in;
        logic [31:0] in_w [10];
        int          n_out;
        logic [31:0] out_w [20];
        logic [31:0] fin;
        logic [1:0]  cnt;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] src_q [$];
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] rand_words [$];
    logic [31:0] exp_fin;
    logic [1:0]  exp_cnt;
    logic [31:0] fin_word;
    logic [1:0]  fin_cnt;
    int          eof_pulses = 0;
    bit          stall_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Output monitor.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.data_ready || bus.eof_data_partial_ready) begin
                checks++;
                if (bus.data_ready && bus.eof_data_partial_ready) begin
                    errors++;
                    $display("FAIL exclusive_outputs: got both high, required at most one");
                end
            end
            if (bus.data_ready) got_q.push_back(bus.jpeg_bitstream);
            if (bus.eof_data_partial_ready) begin
                eof_pulses++;
                fin_word = bus.jpeg_bitstream;
                fin_cnt  = bus.eof_byte_count;
            end
        end
    end

    // One clock of the upstream FIFO: grant a read seen before the edge, data 1 cycle later.
    task automatic tick();
        logic rd;
        @(negedge clk);
        rd = bus.fifo_read_req;
        if (rd) begin
            checks++;
            if (bus.fifo_empty) begin
                errors++;
                $display("FAIL read_while_empty: got fifo_read_req=1 with fifo_empty=1, required 0");
            end
        end
        @(posedge clk);
        #1;
        bus.eof_in = 1'b0;
        if (rd && src_q.size() > 0) begin
            bus.fifo_rdata       = src_q.pop_front();
            bus.fifo_rdata_valid = 1'b1;
        end else begin
            bus.fifo_rdata       = $urandom;
            bus.fifo_rdata_valid = 1'b0;
        end
        bus.fifo_empty = (src_q.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));
    endtask

    task automatic start_capture();
        got_q.delete();
        eof_pulses = 0;
    endtask

    // Reference: stuff bytes into a flat stream, cut into words, remainder is the final word.
    task automatic model_expected();
        logic [7:0] bq [$];
        logic [7:0] b;
        foreach (rand_words[w]) begin
            for (int k = 0; k < 4; k++) begin
                b = rand_words[w][31 - 8*k -: 8];
                bq.push_back(b);
                if (b == 8'hFF) bq.push_back(8'h00);
            end
        end
        exp_q.delete();
        while (bq.size() >= 4) begin
            exp_q.push_back({bq[0], bq[1], bq[2], bq[3]});
            for (int k = 0; k < 4; k++) void'(bq.pop_front());
        end
        exp_cnt = 2'(bq.size());
        exp_fin = '0;
        for (int k = 0; k < bq.size(); k++) exp_fin[31 - 8*k -: 8] = bq[k];
    endtask

    task automatic run_frame(input string name, input bit stall);
        stall_en = stall;
        bus.fifo_empty = (src_q.size() == 0);
        repeat ($urandom_range(0, 3)) tick();
        stall_en = 1'b0;
        bus.fifo_empty = (src_q.size() == 0);
        bus.eof_in = 1'b1;
        tick();
        for (int c = 0; c < 400 && eof_pulses == 0; c++) tick();
        if (eof_pulses == 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no eof_data_partial_ready, required one pulse", name);
        end
        repeat (3) tick();
        check({name, " word_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s word%0d", name, i),
                  64'((i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx), 64'(exp_q[i]));
        end
        check({name, " eof_pulses"}, 64'(eof_pulses), 64'd1);
        check({name, " final_word"}, 64'(fin_word), 64'(exp_fin));
        check({name, " final_count"}, 64'(fin_cnt), 64'(exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0].name = "no_ff";      vecs[0].n_in = 2; vecs[0].n_out = 2;
        vecs[0].in_w[0] = 32'h11223344; vecs[0].in_w[1] = 32'h55667788;
        vecs[0].out_w[0] = 32'h11223344; vecs[0].out_w[1] = 32'h55667788;
        vecs[0].fin = 32'h0; vecs[0].cnt = 2'd0;

        vecs[1].name = "ff_lead";    vecs[1].n_in = 1; vecs[1].n_out = 1;
        vecs[1].in_w[0] = 32'hFF123456; vecs[1].out_w[0] = 32'hFF001234;
        vecs[1].fin = 32'h56000000; vecs[1].cnt = 2'd1;

        vecs[2].name = "empty_eof";  vecs[2].n_in = 0; vecs[2].n_out = 0;
        vecs[2].fin = 32'h0; vecs[2].cnt = 2'd0;

        vecs[3].name = "all_ff";     vecs[3].n_in = 10; vecs[3].n_out = 20;
        for (int i = 0; i < 10; i++) vecs[3].in_w[i] = 32'hFFFFFFFF;
        for (int i = 0; i < 20; i++) vecs[3].out_w[i] = 32'hFF00FF00;
        vecs[3].fin = 32'h0; vecs[3].cnt = 2'd0;

        vecs[4].name = "ff_mid";     vecs[4].n_in = 1; vecs[4].n_out = 1;
        vecs[4].in_w[0] = 32'h00FF00FF; vecs[4].out_w[0] = 32'h00FF0000;
        vecs[4].fin = 32'hFF000000; vecs[4].cnt = 2'd2;

        vecs[5].name = "ff_tail";    vecs[5].n_in = 2; vecs[5].n_out = 2;
        vecs[5].in_w[0] = 32'h12345678; vecs[5].in_w[1] = 32'h9ABCDEFF;
        vecs[5].out_w[0] = 32'h12345678; vecs[5].out_w[1] = 32'h9ABCDEFF;
        vecs[5].fin = 32'h00000000; vecs[5].cnt = 2'd1;

        vecs[6].name = "three_left"; vecs[6].n_in = 1; vecs[6].n_out = 1;
        vecs[6].in_w[0] = 32'hFFFFFF12; vecs[6].out_w[0] = 32'hFF00FF00;
        vecs[6].fin = 32'hFF001200; vecs[6].cnt = 2'd3;

        bus.fifo_empty       = 1'b0;
        bus.fifo_rdata       = '0;
        bus.fifo_rdata_valid = 1'b0;
        bus.eof_in           = 1'b0;
        rst                  = 1'b0;

        // Reset state, with a non-empty FIFO to prove reads stay off.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset jpeg_bitstream", 64'(bus.jpeg_bitstream), 64'd0);
        check("reset data_ready", 64'(bus.data_ready), 64'd0);
        check("reset eof_pulse", 64'(bus.eof_data_partial_ready), 64'd0);
        check("reset eof_byte_count", 64'(bus.eof_byte_count), 64'd0);
        check("reset fifo_read_req", 64'(bus.fifo_read_req), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.fifo_empty = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < NVEC; v++) begin
            src_q.delete();
            for (int i = 0; i < vecs[v].n_in; i++) src_q.push_back(vecs[v].in_w[i]);
            exp_q.delete();
            for (int i = 0; i < vecs[v].n_out; i++) exp_q.push_back(vecs[v].out_w[i]);
            exp_fin = vecs[v].fin;
            exp_cnt = vecs[v].cnt;
            start_capture();
            run_frame(vecs[v].name, 1'b0);
        end

        // Mid-image reset with 6 bytes buffered.
        src_q.delete();
        src_q.push_back(32'hFFFF1122);
        bus.fifo_empty = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        src_q.delete();
        src_q.push_back(32'h11111111);
        bus.fifo_empty = 1'b0;
        @(negedge clk);
        check("midreset fifo_read_req", 64'(bus.fifo_read_req), 64'd0);
        @(posedge clk);
        #1;
        bus.fifo_rdata_valid = 1'b0;
        @(negedge clk);
        check("midreset jpeg_bitstream", 64'(bus.jpeg_bitstream), 64'd0);
        check("midreset data_ready", 64'(bus.data_ready), 64'd0);
        check("midreset eof_pulse", 64'(bus.eof_data_partial_ready), 64'd0);
        check("midreset eof_byte_count", 64'(bus.eof_byte_count), 64'd0);
        @(posedge clk);
        #1;
        src_q.delete();
        start_capture();
        rst                  = 1'b1;
        bus.fifo_empty       = 1'b1;
        bus.fifo_rdata       = 32'hDEADBEEF;
        bus.fifo_rdata_valid = 1'b1;
        tick();
        src_q.push_back(32'hAABBCCDD);
        exp_q.delete();
        exp_q.push_back(32'hAABBCCDD);
        exp_fin = '0;
        exp_cnt = 2'd0;
        run_frame("post_reset", 1'b0);

        for (int f = 0; f < 24; f++) begin
            rand_words.delete();
            for (int w = 0; w < $urandom_range(0, 6); w++) begin
                logic [31:0] word;
                for (int k = 0; k < 4; k++) begin
                    word[31 - 8*k -: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                end
                rand_words.push_back(word);
            end
            model_expected();
            src_q = rand_words;
            start_capture();
            run_frame($sformatf("rand%0d", f), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
